adc_rx_frontend: RTL and testbench
==================================

Name: adc_rx_frontend

Overview:
- Receive-side counterpart of the DAC output path: captures offset-binary 16-bit ADC samples, converts them to signed sfix18_En16, and optionally removes DC with a leaky integrator.
- Buffers the samples in a show-ahead FIFO and presents them to the OFDM receiver on a valid/ready interface.
- Discards a settle window after start-up or clear, and reports clipping and overflow status.

Parameters:
- FIFO_DEPTH, 16, FIFO entries; power of two, 4..256.
- DC_SHIFT, 8, DC estimator time constant as a power of two (K).
- SETTLE_SAMPLES, 64, accepted samples discarded after reset/clear before output starts; 0 = no discard.

Ports:
- clk_in  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- clk_enable  in  1  capture enable; low = adc_valid ignored.
- adc_data  in  16  ADC sample, offset binary (16'h8000 = 0).
- adc_valid  in  1  adc_data qualifier.
- dc_bypass  in  1  1 = DC removal off, estimator frozen.
- clear  in  1  one-cycle pulse: flush FIFO, zero estimator and clip_count, clear overflow, restart settle.
- rx_data_re  out  18  sfix18_En16 sample at FIFO head.
- rx_valid  out  1  FIFO non-empty and FSM in RUN.
- rx_ready  in  1  receiver accepts; transfer = rx_valid & rx_ready.
- fifo_level  out  log2(FIFO_DEPTH)+1  current occupancy.
- overflow  out  1  sticky; a sample was dropped because the FIFO was full.
- clip_count  out  16  saturating count of clipped ADC codes.
- settling  out  1  high in SETTLE.

Behaviour:
- Reset values: all outputs 0, FIFO empty, estimator 0, FSM = IDLE.
- Accept condition: clk_enable & adc_valid.

Stage S1 (registered on accept):
- x = {~adc_data[15], adc_data[14:0], 2'b00}. This is the exact inverse of the transmit {!d[17], d[16:2]} mapping.
- Clip flag set when adc_data == 16'h0000 or 16'hFFFF. Each clip increments clip_count, which saturates at 16'hFFFF and does not wrap.

Stage S2 (one cycle after S1):
- Accumulator acc is signed, 18+DC_SHIFT bits.
- dc = acc >>> DC_SHIFT.
- y = sat18(x − dc). Saturation bounds are 18'h1FFFF and 18'h20000.
- Update acc <= acc + x − dc, only when not bypassed.
- Bypass: y = x, acc held.

FIFO write:
- S2 result is written on the next edge, so latency is 3 edges from accept to rx_valid when the FIFO is empty.
- Only the S1/S2 valid bits stall, never the data.

FSM:
- IDLE -> SETTLE on the first accept.
- SETTLE: samples traverse S1/S2 and update the estimator but are not written. A counter counts S2 outputs; on reaching SETTLE_SAMPLES -> RUN. If SETTLE_SAMPLES = 0, go directly IDLE -> RUN.
- RUN: S2 outputs are written to the FIFO. The FSM stays in RUN until rst or clear.
- clear (any state) -> IDLE next edge. In-flight S1/S2 samples are discarded and fifo_level = 0 next cycle. clear has priority over any simultaneous write or read.

FIFO:
- Show-ahead: rx_data_re is the head word, stable while rx_valid & ~rx_ready.
- Simultaneous read and write when full: the read frees a slot, so the write succeeds and there is no overflow.
- Write when full with no read: the sample is dropped and overflow <= 1.
- rx_data_re is 0 while empty.

clk_enable low:
- New captures are blocked; S1/S2 contents still drain into the FIFO.
- The read side is unaffected.

Reset mid-operation:
- Asynchronous clear of all state, including stage valid bits.
- No partial word reaches the FIFO after release.

Test Plan:
- SETTLE_SAMPLES=0, dc_bypass=1; feed 16'h8000, 16'hC000, 16'h4000, 16'hFFFF, 16'h0000 with rx_ready=1 -> rx_data_re 18'h00000, 18'h10000, 18'h30000, 18'h1FFFC, 18'h20000; first rx_valid 3 cycles after first accept; clip_count=2.
- dc_bypass=0, DC_SHIFT=4, constant adc_data=16'hA000 (x=18'h08000) for 512 samples -> output decays monotonically toward 0; |rx_data_re| < 18'h00100 after 300 samples. Then dc_bypass=1 -> output returns to 18'h08000.
- SETTLE_SAMPLES=64, continuous input -> settling high for the settle window; exactly 64 samples discarded; 65th sample is the first FIFO word.
- FIFO_DEPTH=16, rx_ready=0, 20 samples in RUN -> fifo_level=16, overflow=1, first 16 samples preserved in order. Then rx_ready=1 with an input on the same cycle while full -> no further drop. clear -> fifo_level=0, overflow=0, clip_count=0, FSM IDLE.
- Random rx_ready backpressure, 1000 samples under the fill level -> rx_data_re stable while stalled; no loss, duplication, or reordering against the reference model.
- Assert rst while 2 samples are in S1/S2 and the FIFO is half full -> all outputs 0 immediately; after release, first output is 3 cycles after the next accept.

Source files
------------

// File: rtl/adc_rx_frontend.sv
`default_nettype none
// ============================================================================
//  Module      : adc_rx_frontend
//  Description : ADC receive front end. Captures offset-binary 16-bit samples,
//                converts them to signed sfix18_En16, optionally removes DC
//                with a leaky integrator, drops a settle window after start-up
//                or clear, and buffers the result in a show-ahead FIFO with a
//                valid/ready output.
//  Ports       : clk_in, rst (async, active high)
//                clk_enable, adc_data[15:0], adc_valid  - capture side
//                dc_bypass, clear                       - control
//                rx_data_re[17:0], rx_valid, rx_ready   - receiver side
//                fifo_level, overflow, clip_count[15:0], settling - status
//  Revision    : 1.0 - initial release
// ============================================================================
module adc_rx_frontend #(
    parameter int FIFO_DEPTH     = 16,
    parameter int DC_SHIFT       = 8,
    parameter int SETTLE_SAMPLES = 64
) (
    input  logic                          clk_in,
    input  logic                          rst,
    input  logic                          clk_enable,
    input  logic [15:0]                   adc_data,
    input  logic                          adc_valid,
    input  logic                          dc_bypass,
    input  logic                          clear,
    output logic [17:0]                   rx_data_re,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    output logic [15:0]                   clip_count,
    output logic                          settling
);

    localparam int c_AW          = $clog2(FIFO_DEPTH);
    localparam int c_ACC_W       = 18 + DC_SHIFT;
    localparam int c_CNT_W       = (SETTLE_SAMPLES > 1) ? $clog2(SETTLE_SAMPLES) : 1;
    localparam int c_SETTLE_LAST_I = (SETTLE_SAMPLES > 0) ? SETTLE_SAMPLES - 1 : 0;
    localparam logic [c_CNT_W-1:0] c_SETTLE_LAST = c_CNT_W'(c_SETTLE_LAST_I);
    localparam logic [c_AW:0]      c_FULL        = (c_AW+1)'(FIFO_DEPTH);
    localparam logic [c_AW:0]      c_LVL_ONE     = (c_AW+1)'(1);
    localparam logic [c_AW-1:0]    c_PTR_ONE     = c_AW'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE     = c_CNT_W'(1);
    localparam logic signed [c_ACC_W:0] c_SAT_MAX = (c_ACC_W+1)'(131071);
    localparam logic signed [c_ACC_W:0] c_SAT_MIN = -(c_ACC_W+1)'(131072);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RUN    = 2'd2
    } state_t;

    state_t r_state;
    logic [c_CNT_W-1:0] r_settle_cnt;

    // ------------------------------------------------------------------
    // Stage S1: offset binary -> two's complement, left-justified in 18 bits
    // ------------------------------------------------------------------
    logic        w_accept;
    logic        w_clip;
    logic [17:0] w_x;
    logic        r_s1_valid;
    logic [17:0] r_s1_x;

    assign w_accept = clk_enable & adc_valid;
    assign w_clip   = (adc_data == 16'h0000) | (adc_data == 16'hFFFF);
    assign w_x      = {~adc_data[15], adc_data[14:0], 2'b00};

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_x     <= '0;
        end else begin
            r_s1_valid <= w_accept & ~clear;
            if (w_accept) begin
                r_s1_x <= w_x;
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            clip_count <= '0;
        end else if (clear) begin
            clip_count <= '0;
        end else if (w_accept && w_clip && (clip_count != 16'hFFFF)) begin
            clip_count <= clip_count + 16'd1;
        end
    end

    // ------------------------------------------------------------------
    // Stage S2: leaky-integrator DC removal with 18-bit saturation.
    // The difference is formed one bit wider than the accumulator so the
    // saturation test sees the true sign.
    // ------------------------------------------------------------------
    logic signed [c_ACC_W-1:0] r_acc;
    logic signed [c_ACC_W-1:0] w_dc;
    logic signed [c_ACC_W:0]   w_x_ext;
    logic signed [c_ACC_W:0]   w_dc_ext;
    logic signed [c_ACC_W:0]   w_diff;
    logic signed [c_ACC_W-1:0] w_acc_next;
    logic [17:0]               w_sat;
    logic                      r_s2_valid;
    logic [17:0]               r_s2_y;

    assign w_dc       = r_acc >>> DC_SHIFT;
    assign w_x_ext    = {{(c_ACC_W-17){r_s1_x[17]}}, r_s1_x};
    assign w_dc_ext   = {w_dc[c_ACC_W-1], w_dc};
    assign w_diff     = w_x_ext - w_dc_ext;
    assign w_acc_next = r_acc + w_diff[c_ACC_W-1:0];

    always_comb begin
        w_sat = w_diff[17:0];
        if (w_diff > c_SAT_MAX) begin
            w_sat = 18'h1FFFF;
        end else if (w_diff < c_SAT_MIN) begin
            w_sat = 18'h20000;
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_s2_y     <= '0;
            r_acc      <= '0;
        end else begin
            r_s2_valid <= r_s1_valid & ~clear;
            if (clear) begin
                r_acc <= '0;
            end else if (r_s1_valid && !dc_bypass) begin
                r_acc <= w_acc_next;
            end
            if (r_s1_valid) begin
                r_s2_y <= dc_bypass ? r_s1_x : w_sat;
            end
        end
    end

    // ------------------------------------------------------------------
    // Control FSM: the settle counter counts S2 results consumed while
    // settling; the one that reaches the limit is still discarded.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_settle_cnt <= '0;
        end else if (clear) begin
            r_state      <= ST_IDLE;
            r_settle_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_settle_cnt <= '0;
                    if (w_accept) begin
                        r_state <= (SETTLE_SAMPLES == 0) ? ST_RUN : ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (r_s2_valid) begin
                        if (r_settle_cnt == c_SETTLE_LAST) begin
                            r_state <= ST_RUN;
                        end else begin
                            r_settle_cnt <= r_settle_cnt + c_CNT_ONE;
                        end
                    end
                end
                ST_RUN:  r_state <= ST_RUN;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign settling = (r_state == ST_SETTLE);

    // ------------------------------------------------------------------
    // Show-ahead FIFO. A read in the same cycle as a write into a full
    // FIFO frees the slot, so the write is accepted.
    // ------------------------------------------------------------------
    logic [17:0]     r_mem [FIFO_DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_AW:0]   r_level;
    logic            w_write_req;
    logic            w_write;
    logic            w_read;
    logic            w_full;

    assign w_full      = (r_level == c_FULL);
    assign w_write_req = r_s2_valid & (r_state == ST_RUN);
    assign w_read      = rx_valid & rx_ready;
    assign w_write     = w_write_req & (~w_full | w_read);

    always_ff @(posedge clk_in) begin
        if (w_write && !clear) begin
            r_mem[r_wr_ptr] <= r_s2_y;
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            overflow <= 1'b0;
        end else if (clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            overflow <= 1'b0;
        end else begin
            if (w_write) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_read) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            if (w_write && !w_read) begin
                r_level <= r_level + c_LVL_ONE;
            end else if (!w_write && w_read) begin
                r_level <= r_level - c_LVL_ONE;
            end
            if (w_write_req && w_full && !w_read) begin
                overflow <= 1'b1;
            end
        end
    end

    assign rx_valid   = (r_level != '0) & (r_state == ST_RUN);
    assign rx_data_re = rx_valid ? r_mem[r_rd_ptr] : 18'h00000;
    assign fifo_level = r_level;

endmodule
`default_nettype wire

// File: tb/tb_adc_rx_frontend.sv
`default_nettype none
// ============================================================================
//  Module      : tb_adc_rx_frontend
//  Description : Self-checking bench for adc_rx_frontend. Two instances share
//                the stimulus: A (SETTLE_SAMPLES=0) and B (SETTLE_SAMPLES=64),
//                both FIFO_DEPTH=16, DC_SHIFT=4. A transaction-level model
//                predicts every output each cycle; literal values pin it.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_adc_rx_frontend;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clk_enable = 1'b1;
    logic [15:0] adc_data = 16'h8000;
    logic        adc_valid = 1'b0;
    logic        dc_bypass = 1'b1;
    logic        clear = 1'b0;
    logic        rx_ready = 1'b1;

    logic [17:0] a_data, b_data;
    logic        a_valid, b_valid, a_ovf, b_ovf, a_settling, b_settling;
    logic [4:0]  a_level, b_level;
    logic [15:0] a_clip, b_clip;

    always #5 clk = ~clk;

    adc_rx_frontend #(.FIFO_DEPTH(16), .DC_SHIFT(4), .SETTLE_SAMPLES(0)) dut_a (
        .clk_in(clk), .rst(rst), .clk_enable(clk_enable), .adc_data(adc_data),
        .adc_valid(adc_valid), .dc_bypass(dc_bypass), .clear(clear),
        .rx_data_re(a_data), .rx_valid(a_valid), .rx_ready(rx_ready),
        .fifo_level(a_level), .overflow(a_ovf), .clip_count(a_clip),
        .settling(a_settling));

    adc_rx_frontend #(.FIFO_DEPTH(16), .DC_SHIFT(4), .SETTLE_SAMPLES(64)) dut_b (
        .clk_in(clk), .rst(rst), .clk_enable(clk_enable), .adc_data(adc_data),
        .adc_valid(adc_valid), .dc_bypass(dc_bypass), .clear(clear),
        .rx_data_re(b_data), .rx_valid(b_valid), .rx_ready(rx_ready),
        .fifo_level(b_level), .overflow(b_ovf), .clip_count(b_clip),
        .settling(b_settling));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    int     settle_n [2] = '{0, 64};
    int     mq [2][$];
    int     mphase [2];          // 0 idle, 1 settling, 2 running
    int     mcnt [2];
    bit     movf [2];
    int     mclip;
    longint macc;
    bit     mp1v, mp2v;
    int     mp1y, mp2y;

    function automatic int model_y(input logic [15:0] d, input bit byp);
        longint x, dc, v;
        x = (longint'(d) - 32768) * 4;
        if (byp) return int'(x);
        dc = macc >>> 4;
        v = x - dc;
        macc = macc + v;
        if (v > 131071) v = 131071;
        if (v < -131072) v = -131072;
        return int'(v);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst || clear) begin
            for (int i = 0; i < 2; i++) begin
                mq[i].delete();
                mphase[i] = 0;
                mcnt[i] = 0;
                movf[i] = 1'b0;
            end
            mclip = 0; macc = 0; mp1v = 1'b0; mp2v = 1'b0; mp1y = 0; mp2y = 0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                int old;
                old = mphase[i];
                if (mq[i].size() > 0 && rx_ready) void'(mq[i].pop_front());
                if (mp2v) begin
                    if (old == 2) begin
                        if (mq[i].size() < 16) mq[i].push_back(mp2y);
                        else movf[i] = 1'b1;
                    end else if (old == 1) begin
                        mcnt[i]++;
                        if (mcnt[i] == settle_n[i]) mphase[i] = 2;
                    end
                end
                if (old == 0 && clk_enable && adc_valid)
                    mphase[i] = (settle_n[i] == 0) ? 2 : 1;
            end
            mp2v = mp1v; mp2y = mp1y;
            mp1v = clk_enable & adc_valid;
            if (mp1v) begin
                mp1y = model_y(adc_data, dc_bypass);
                if ((adc_data == 16'h0000 || adc_data == 16'hFFFF) && mclip < 65535) mclip++;
            end
        end
    end

    // ---------------- per-cycle comparison ----------------
    always @(negedge clk) begin
        logic [17:0] ed;
        logic        ev;
        ev = (mq[0].size() > 0);
        ed = ev ? 18'(mq[0][0]) : 18'h0;
        chk("a_rx_valid", a_valid, ev);
        chk("a_rx_data", a_data, ed);
        chk("a_level", a_level, mq[0].size());
        chk("a_overflow", a_ovf, movf[0]);
        chk("a_clip", a_clip, mclip);
        chk("a_settling", a_settling, mphase[0] == 1);
        ev = (mq[1].size() > 0);
        ed = ev ? 18'(mq[1][0]) : 18'h0;
        chk("b_rx_valid", b_valid, ev);
        chk("b_rx_data", b_data, ed);
        chk("b_level", b_level, mq[1].size());
        chk("b_overflow", b_ovf, movf[1]);
        chk("b_clip", b_clip, mclip);
        chk("b_settling", b_settling, mphase[1] == 1);
    end

    // words actually transferred to the receiver
    logic [17:0] a_words[$], b_words[$];
    always @(negedge clk) begin
        if (a_valid && rx_ready) a_words.push_back(a_data);
        if (b_valid && rx_ready) b_words.push_back(b_data);
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        adc_valid = 1'b0;
        repeat (n) cyc();
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        cyc();
        clear = 1'b0;
    endtask

    logic [15:0] t1_in  [5] = '{16'h8000, 16'hC000, 16'h4000, 16'hFFFF, 16'h0000};
    logic [17:0] t1_out [5] = '{18'h00000, 18'h10000, 18'h30000, 18'h1FFFC, 18'h20000};

    initial begin
        logic signed [17:0] s;
        int nacc;
        repeat (3) cyc();
        chk("reset_valid", a_valid, 1'b0);
        chk("reset_level", a_level, 5'd0);
        chk("reset_data", a_data, 18'h0);
        chk("reset_clip", a_clip, 16'h0);
        rst = 1'b0;
        cyc();

        // 1: format conversion, latency, clipping
        a_words.delete();
        adc_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            adc_data = t1_in[i];
            cyc();
            if (i < 2) chk("latency_early", a_valid, 1'b0);
            if (i == 2) chk("latency_first", a_valid, 1'b1);
        end
        idle(6);
        for (int i = 0; i < 5; i++) chk("conv_word", a_words[i], t1_out[i]);
        chk("conv_clip", a_clip, 16'd2);

        // 2: DC removal, then bypass restores the raw value
        pulse_clear();
        dc_bypass = 1'b0;
        a_words.delete();
        adc_data = 16'hA000;
        adc_valid = 1'b1;
        for (int n = 0; n < 512; n++) begin
            cyc();
            if (n == 305) begin
                s = a_data;
                chk("dc_decayed", (s < 18'sd256) && (s > -18'sd256), 1'b1);
            end
        end
        idle(4);
        chk("dc_first", a_words[0], 18'h08000);
        chk("dc_second", a_words[1], 18'h07800);
        dc_bypass = 1'b1;
        a_words.delete();
        adc_valid = 1'b1;
        repeat (4) cyc();
        idle(5);
        chk("bypass_count", a_words.size(), 4);
        chk("bypass_value", a_words[3], 18'h08000);

        // 3: settle window on instance B
        pulse_clear();
        b_words.delete();
        adc_valid = 1'b1;
        for (int i = 0; i < 80; i++) begin
            adc_data = 16'h8000 + 16'(i);
            cyc();
            if (i == 0 || i == 64) chk("settle_high", b_settling, 1'b1);
            if (i == 65) chk("settle_low", b_settling, 1'b0);
        end
        idle(6);
        chk("settle_first", b_words[0], 18'h00100);
        chk("settle_count", b_words.size(), 16);

        // 4a: full FIFO, read and write on the same edge
        pulse_clear();
        for (int c = 0; c < 20; c++) begin
            adc_valid = (c < 17);
            adc_data = 16'h8000 + 16'(c * 256);
            rx_ready = (c == 18);
            cyc();
        end
        chk("full_rw_level", a_level, 5'd16);
        chk("full_rw_ovf", a_ovf, 1'b0);

        // 4b: overflow with no reads, then clear
        pulse_clear();
        adc_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            adc_data = (c == 0) ? 16'h0000 : 16'h8000 + 16'(c);
            cyc();
        end
        idle(3);
        chk("ovf_level", a_level, 5'd16);
        chk("ovf_flag", a_ovf, 1'b1);
        chk("ovf_clip", a_clip, 16'd1);
        a_words.delete();
        rx_ready = 1'b1;
        idle(20);
        chk("ovf_drain_count", a_words.size(), 16);
        chk("ovf_drain_first", a_words[0], 18'h20000);
        chk("ovf_drain_last", a_words[15], 18'h0003C);
        pulse_clear();
        chk("clear_level", a_level, 5'd0);
        chk("clear_ovf", a_ovf, 1'b0);
        chk("clear_clip", a_clip, 16'd0);
        chk("clear_settling", b_settling, 1'b0);

        // 5: random backpressure and capture gating
        dc_bypass = 1'b0;
        a_words.delete();
        nacc = 0;
        for (int n = 0; n < 4000 && nacc < 1000; n++) begin
            clk_enable = ($urandom_range(0, 7) != 0);
            adc_valid  = ($urandom_range(0, 2) == 0);
            adc_data   = 16'($urandom);
            rx_ready   = ($urandom_range(0, 2) != 0);
            if (clk_enable && adc_valid) nacc++;
            cyc();
        end
        clk_enable = 1'b1;
        rx_ready = 1'b1;
        idle(40);
        chk("rand_count", a_words.size(), nacc);
        chk("rand_ovf", a_ovf, 1'b0);

        // 6: asynchronous reset with data in flight
        pulse_clear();
        dc_bypass = 1'b1;
        rx_ready = 1'b0;
        adc_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            adc_data = 16'h8000 + 16'(i);
            cyc();
        end
        chk("pre_rst_level", a_level, 5'd8);
        rst = 1'b1;
        adc_valid = 1'b0;
        #1;
        chk("rst_level", a_level, 5'd0);
        chk("rst_valid", a_valid, 1'b0);
        chk("rst_data", a_data, 18'h0);
        chk("rst_b_settling", b_settling, 1'b0);
        cyc();
        rst = 1'b0;
        idle(3);
        adc_data = 16'h9000;
        adc_valid = 1'b1;
        cyc();
        chk("post_rst_e0", a_valid, 1'b0);
        adc_valid = 1'b0;
        cyc();
        chk("post_rst_e1", a_valid, 1'b0);
        cyc();
        chk("post_rst_e2", a_valid, 1'b1);
        chk("post_rst_data", a_data, 18'h04000);
        chk("post_rst_level", a_level, 5'd1);
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
